rv32i_iterative_multiplier_16x16: RTL and testbench



---
 rtl/rv32i_iterative_multiplier_16x16.sv | 171 +++++++++++++++++
 tb/tb_rv32i_iterative_multiplier_16x16.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_iterative_multiplier_16x16.sv
// ---------------------------------------------------------------------------
// rv32i_iterative_multiplier_16x16
//
// Sequential unsigned 16x16 -> 32 shift-add multiplier serving the
// execute-stage multiplier/shift controlpath. STEP_BITS multiplier bits are
// retired per cycle (1 = radix-2, 2 = radix-4). A one-cycle valid pulse
// returns the product; a RELEASE state waits for the enable to drop so that
// a held enable cannot start a second operation.
//
// Optional feature macro: RV32I_MULT_EARLY_TERMINATE_EN
//   When defined, an operation finishes as soon as the remaining multiplier
//   bits are all zero (including op2 == 0 at capture).
//
// Ports:
//   i_clk                     clock, rising edge
//   i_rst                     synchronous active-high reset
//   i_multiplier_en           request; operands sampled while IDLE
//   i_multiplier_operand_one  16-bit unsigned multiplicand
//   i_multiplier_operand_two  16-bit unsigned multiplier
//   o_multiplier_valid        one-cycle pulse, result valid in that cycle
//   o_multiplier_result       32-bit product, held until the next completion
//   o_multiplier_busy         high whenever the state is not IDLE
// ---------------------------------------------------------------------------
module rv32i_iterative_multiplier_16x16 #(
  parameter int STEP_BITS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_multiplier_en,
  input  logic [15:0] i_multiplier_operand_one,
  input  logic [15:0] i_multiplier_operand_two,
  output logic        o_multiplier_valid,
  output logic [31:0] o_multiplier_result,
  output logic        o_multiplier_busy
);

  localparam int DIGITS = 16 / STEP_BITS;
  localparam int CNT_W  = $clog2(DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  generate
    if (!(STEP_BITS == 1 || STEP_BITS == 2)) begin : g_bad_step
      $error("STEP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [31:0]      mcand_q;
  logic [15:0]      mplier_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic [31:0]      result_q;
  logic             busy_q;

  // Next values for one MUL iteration.
  logic [1:0]       digit;
  logic [31:0]      acc_d;
  logic [31:0]      mcand_d;
  logic [15:0]      mplier_d;
  logic [CNT_W-1:0] count_d;
  logic             mul_last;

  // Partial product for one multiplier digit; digit 3 (radix-4 only) is
  // built from a shift and an add rather than a real multiply.
  function automatic logic [31:0] partial_product(input logic [31:0] mc,
                                                  input logic [1:0]  dig);
    logic [31:0] pp;
    case (dig)
      2'd0:    pp = 32'h0;
      2'd1:    pp = mc;
      2'd2:    pp = mc << 1;
      default: pp = mc + (mc << 1);
    endcase
    return pp;
  endfunction

  always_comb begin
    digit    = 2'(mplier_q[STEP_BITS-1:0]);
    acc_d    = acc_q + partial_product(mcand_q, digit);
    mcand_d  = mcand_q << STEP_BITS;
    mplier_d = mplier_q >> STEP_BITS;
    count_d  = count_q + CNT_W'(1);
`ifdef RV32I_MULT_EARLY_TERMINATE_EN
    // Stop once no set multiplier bits remain after this step's shift.
    mul_last = (count_q == LAST_CNT) || (mplier_d == 16'h0);
`else
    mul_last = (count_q == LAST_CNT);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'h0;
      mplier_q <= 16'h0;
      acc_q    <= 32'h0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= 32'h0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_multiplier_en) begin
            mcand_q  <= {16'h0, i_multiplier_operand_one};
            mplier_q <= i_multiplier_operand_two;
            acc_q    <= 32'h0;
            count_q  <= '0;
            busy_q   <= 1'b1;
`ifdef RV32I_MULT_EARLY_TERMINATE_EN
            if (i_multiplier_operand_two == 16'h0) begin
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= 32'h0;
            end else begin
              state_q  <= S_MUL;
            end
`else
            state_q <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          count_q  <= count_d;
          if (mul_last) begin
            // Valid and result are registered on entry to DONE so both are
            // visible during the DONE cycle.
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= acc_d;
          end
        end
        S_DONE: begin
          if (i_multiplier_en) begin
            state_q <= S_RELEASE;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!i_multiplier_en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_multiplier_valid  = valid_q;
  assign o_multiplier_result = result_q;
  assign o_multiplier_busy   = busy_q;

endmodule

// File: tb/tb_rv32i_iterative_multiplier_16x16.sv
// ---------------------------------------------------------------------------
// Directed bench for rv32i_iterative_multiplier_16x16. A radix-2 and a
// radix-4 instance share the same stimulus. Cycle 0 is the cycle in which
// the enable is first presented; cycle n is observed 1 ns after the n-th
// following rising edge.
// ---------------------------------------------------------------------------
module tb_rv32i_iterative_multiplier_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        v1, v2, b1, b2;
  logic [31:0] r1, r2;

  int checks   = 0;
  int failures = 0;

  // Results of the most recent do_op call.
  int          k1, k2, n1, n2, idle1;
  logic [31:0] res1, res2;
  logic        busy_ok;

  always #5 clk = ~clk;

  rv32i_iterative_multiplier_16x16 #(.STEP_BITS(1)) u_r2 (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_multiplier_en          (en),
    .i_multiplier_operand_one (op1),
    .i_multiplier_operand_two (op2),
    .o_multiplier_valid       (v1),
    .o_multiplier_result      (r1),
    .o_multiplier_busy        (b1)
  );

  rv32i_iterative_multiplier_16x16 #(.STEP_BITS(2)) u_r4 (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_multiplier_en          (en),
    .i_multiplier_operand_one (op1),
    .i_multiplier_operand_two (op2),
    .o_multiplier_valid       (v2),
    .o_multiplier_result      (r2),
    .o_multiplier_busy        (b2)
  );

  // Cycle in which valid is expected for a given multiplier operand.
  function automatic int exp_lat(input int b, input int step);
`ifdef RV32I_MULT_EARLY_TERMINATE_EN
    int h;
    h = -1;
    for (int i = 0; i < 16 / step; i++)
      if (((b >> (i * step)) & ((1 << step) - 1)) != 0) h = i;
    if (h < 0) return 1;
    return h + 2;
`else
    return 16 / step + 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation. Enable stays high through the radix-2 valid cycle
  // plus 'hold' further cycles, then drops. Operands are scrambled right
  // after capture to show they are not re-sampled.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    k1 = -1; k2 = -1; n1 = 0; n2 = 0; idle1 = -1;
    res1 = 32'h0; res2 = 32'h0; busy_ok = 1'b1;
    op1 = a; op2 = b; en = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      if (cyc == 1) begin op1 = 16'hA5A5; op2 = 16'h5A5A; end
      if (v1) begin n1++; if (k1 < 0) begin k1 = cyc; res1 = r1; end end
      if (v2) begin n2++; if (k2 < 0) begin k2 = cyc; res2 = r2; end end
      if (idle1 < 0) begin
        if (!b1 && k1 >= 0) idle1 = cyc;
        else if (!b1) busy_ok = 1'b0;
      end
      if (k1 >= 0 && cyc >= k1 + hold + 1) en = 1'b0;
      if (idle1 >= 0 && !b2) break;
    end
    en = 1'b0;
  endtask

  initial begin
    int nv;
    rst = 1'b1; en = 1'b0; op1 = 16'h0; op2 = 16'h0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_valid_r2",  32'(v1), 32'h0);
    chk("rst_busy_r2",   32'(b1), 32'h0);
    chk("rst_result_r2", r1,      32'h0);
    chk("rst_valid_r4",  32'(v2), 32'h0);
    chk("rst_busy_r4",   32'(b2), 32'h0);
    chk("rst_result_r4", r2,      32'h0);
    rst = 1'b0;
    tick();

    // 3 * 4, enable dropped one cycle after valid
    do_op(16'h0003, 16'h0004, 0);
    chk("small_vcyc_r2",   32'(k1),      32'(exp_lat(4, 1)));
    chk("small_npulse_r2", 32'(n1),      32'd1);
    chk("small_res_r2",    res1,         32'h0000000C);
    chk("small_idle_r2",   32'(idle1),   32'(exp_lat(4, 1) + 2));
    chk("small_busy_r2",   32'(busy_ok), 32'd1);
    chk("small_vcyc_r4",   32'(k2),      32'(exp_lat(4, 2)));
    chk("small_res_r4",    res2,         32'h0000000C);

    // Maximum operands (exercises radix-4 digit 3)
    do_op(16'hFFFF, 16'hFFFF, 0);
    chk("max_vcyc_r2",   32'(k1), 32'(exp_lat(16'hFFFF, 1)));
    chk("max_res_r2",    res1,    32'hFFFE0001);
    chk("max_vcyc_r4",   32'(k2), 32'(exp_lat(16'hFFFF, 2)));
    chk("max_res_r4",    res2,    32'hFFFE0001);
    chk("max_npulse_r4", 32'(n2), 32'd1);

    // Mixed digit pattern
    do_op(16'h1234, 16'h5678, 0);
    chk("mix_vcyc_r2", 32'(k1), 32'(exp_lat(16'h5678, 1)));
    chk("mix_res_r2",  res1,    32'h06260060);
    chk("mix_vcyc_r4", 32'(k2), 32'(exp_lat(16'h5678, 2)));
    chk("mix_res_r4",  res2,    32'h06260060);

    // Enable held for 10 cycles after valid: one pulse, RELEASE holds busy
    do_op(16'h1234, 16'h0010, 10);
    chk("hold_vcyc_r2",   32'(k1),      32'(exp_lat(16'h0010, 1)));
    chk("hold_res_r2",    res1,         32'h00012340);
    chk("hold_npulse_r2", 32'(n1),      32'd1);
    chk("hold_npulse_r4", 32'(n2),      32'd1);
    chk("hold_idle_r2",   32'(idle1),   32'(exp_lat(16'h0010, 1) + 12));
    chk("hold_busy_r2",   32'(busy_ok), 32'd1);
    chk("hold_vcyc_r4",   32'(k2),      32'(exp_lat(16'h0010, 2)));
    chk("hold_res_r4",    res2,         32'h00012340);

    // Zero multiplier
    do_op(16'hBEEF, 16'h0000, 0);
    chk("zero_vcyc_r2", 32'(k1), 32'(exp_lat(0, 1)));
    chk("zero_res_r2",  res1,    32'h0);
    chk("zero_vcyc_r4", 32'(k2), 32'(exp_lat(0, 2)));
    chk("zero_res_r4",  res2,    32'h0);

    // Reset asserted in cycle 5 of an operation
    nv = 0;
    op1 = 16'h1234; op2 = 16'h5678; en = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      if (v1 || v2) nv++;
    end
    rst = 1'b1;
    tick();
    chk("abort_busy_r2",   32'(b1), 32'h0);
    chk("abort_result_r2", r1,      32'h0);
    chk("abort_valid_r2",  32'(v1), 32'h0);
    chk("abort_busy_r4",   32'(b2), 32'h0);
    chk("abort_result_r4", r2,      32'h0);
    chk("abort_valid_r4",  32'(v2), 32'h0);
    rst = 1'b0; en = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      tick();
      if (v1 || v2) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);

    // Operation after reset recovery runs at full latency
    do_op(16'h0002, 16'h0003, 0);
    chk("post_vcyc_r2", 32'(k1), 32'(exp_lat(3, 1)));
    chk("post_res_r2",  res1,    32'h00000006);
    chk("post_vcyc_r4", 32'(k2), 32'(exp_lat(3, 2)));
    chk("post_res_r4",  res2,    32'h00000006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
